// File: rtl/key_expansion.sv
// AES-128 key expansion sequencer: streams round keys 0..10 over valid/ready.
// Define KEY_EXP_STORE_EN to keep all 11 round keys for reverse-order readout.

module key_schedule (
    input  logic [127:0] key,
    input  logic [11:0]  round_num,
    output logic [31:0]  g
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (x & {8{b[i]}});
            x = {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [11:0] rn);
        logic [7:0] c;
        case (rn)
            12'd1:   c = 8'h01;
            12'd2:   c = 8'h02;
            12'd3:   c = 8'h04;
            12'd4:   c = 8'h08;
            12'd5:   c = 8'h10;
            12'd6:   c = 8'h20;
            12'd7:   c = 8'h40;
            12'd8:   c = 8'h80;
            12'd9:   c = 8'h1b;
            12'd10:  c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    logic [31:0] w3_s;
    logic        unused_key_s;

    assign w3_s         = key[31:0];
    assign unused_key_s = ^key[127:32];
    assign g = {sbox(w3_s[23:16]) ^ rcon(round_num), sbox(w3_s[15:8]),
                sbox(w3_s[7:0]), sbox(w3_s[31:24])};

endmodule

module key_expansion #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk,
    output logic [3:0]   rk_idx,
    output logic         done
`ifdef KEY_EXP_STORE_EN
    ,
    input  logic [3:0]   rd_addr,
    output logic [127:0] rd_data,
    output logic         store_valid
`endif
);

    if (NUM_ROUNDS != 10) begin : g_bad_rounds
        $error("key_expansion: NUM_ROUNDS must be 10");
    end

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [127:0]  rk_r;
    logic [127:0]  rk_nxt_s;
    logic [3:0]    rk_idx_r;
    logic [3:0]    rk_idx_nxt_s;
    logic          rk_valid_r;
    logic          rk_valid_nxt_s;
    logic          busy_r;
    logic          busy_nxt_s;
    logic          done_r;
    logic          done_nxt_s;
    logic          load_s;
    logic          accept_s;
    logic          hs_s;
    logic          last_s;
    logic [31:0]   g_s;
    logic [31:0]   n0_s;
    logic [31:0]   n1_s;
    logic [31:0]   n2_s;
    logic [31:0]   n3_s;

    assign hs_s     = rk_valid_r & rk_ready;
    assign last_s   = (rk_idx_r == LAST_IDX);
    assign accept_s = (state_r == ST_IDLE) & start;

    // round_num is built from the same registers as the key, so they always agree
    key_schedule u_key_schedule (
        .key       (rk_r),
        .round_num ({8'd0, rk_idx_r + 4'd1}),
        .g         (g_s)
    );

    assign n0_s = rk_r[127:96] ^ g_s;
    assign n1_s = rk_r[95:64]  ^ n0_s;
    assign n2_s = rk_r[63:32]  ^ n1_s;
    assign n3_s = rk_r[31:0]   ^ n2_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_EMIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (hs_s && last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        rk_nxt_s       = rk_r;
        rk_idx_nxt_s   = rk_idx_r;
        rk_valid_nxt_s = 1'b0;
        busy_nxt_s     = 1'b0;
        done_nxt_s     = 1'b0;
        load_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    rk_nxt_s       = key_in;
                    rk_idx_nxt_s   = 4'd0;
                    rk_valid_nxt_s = 1'b1;
                    busy_nxt_s     = 1'b1;
                    load_s         = 1'b1;
                end else begin
                    rk_valid_nxt_s = 1'b0;
                end
            end
            ST_EMIT: begin
                if (hs_s && last_s) begin
                    done_nxt_s = 1'b1;
                end else if (hs_s) begin
                    rk_nxt_s       = {n0_s, n1_s, n2_s, n3_s};
                    rk_idx_nxt_s   = rk_idx_r + 4'd1;
                    rk_valid_nxt_s = 1'b1;
                    busy_nxt_s     = 1'b1;
                    load_s         = 1'b1;
                end else begin
                    rk_valid_nxt_s = 1'b1;
                    busy_nxt_s     = 1'b1;
                end
            end
            default: begin
                rk_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_r       <= 128'd0;
            rk_idx_r   <= 4'd0;
            rk_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            rk_r       <= rk_nxt_s;
            rk_idx_r   <= rk_idx_nxt_s;
            rk_valid_r <= rk_valid_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    assign rk       = rk_r;
    assign rk_idx   = rk_idx_r;
    assign rk_valid = rk_valid_r;
    assign busy     = busy_r;
    assign done     = done_r;

`ifdef KEY_EXP_STORE_EN
    logic [127:0] store_r [0:10];
    logic [127:0] rd_data_r;
    logic         store_valid_r;

    // Key store: written alongside the output register, so each entry lands as its key turns valid
    always_ff @(posedge clk) begin
        if (!rst && load_s) begin
            store_r[rk_idx_nxt_s] <= rk_nxt_s;
        end
    end

    // Registered readout; out-of-range addresses return zero
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= 128'd0;
        end else if (rd_addr <= LAST_IDX) begin
            rd_data_r <= store_r[rd_addr];
        end else begin
            rd_data_r <= 128'd0;
        end
    end

    // Complete-set flag
    always_ff @(posedge clk) begin
        if (rst) begin
            store_valid_r <= 1'b0;
        end else if (accept_s) begin
            store_valid_r <= 1'b0;
        end else if (done_nxt_s) begin
            store_valid_r <= 1'b1;
        end else begin
            store_valid_r <= store_valid_r;
        end
    end

    assign rd_data     = rd_data_r;
    assign store_valid = store_valid_r;
`else
    logic unused_store_s;
    assign unused_store_s = load_s ^ accept_s;
`endif

endmodule

// File: tb/tb_key_expansion.sv
// Scoreboard bench for key_expansion: FIPS-197 A.1 and zero-key vectors, backpressure,
// start-while-busy, mid-sequence reset and (with KEY_EXP_STORE_EN) store readout.

module tb_key_expansion;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         done;
`ifdef KEY_EXP_STORE_EN
    logic [3:0]   rd_addr;
    logic [127:0] rd_data;
    logic         store_valid;
`endif

    key_expansion #(.NUM_ROUNDS(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk       (rk),
        .rk_idx   (rk_idx),
        .done     (done)
`ifdef KEY_EXP_STORE_EN
        ,
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .store_valid (store_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] key;
        logic         chk_key;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    logic [127:0] a1_keys [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    logic [127:0] zero_rk1 = 128'h62636363626363636263636362636363;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: compare the presented key against the scoreboard head; pop on handshake
    always @(negedge clk) begin
        if (!rst && rk_valid) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_valid", {127'd0, rk_valid}, 128'd0);
            end else begin
                check_val("rk_idx", {124'd0, rk_idx}, {124'd0, sb_q[0].idx});
                if (sb_q[0].chk_key) begin
                    check_val("rk", rk, sb_q[0].key);
                end
                check_val("busy_with_valid", {127'd0, busy}, 128'd1);
                if (rk_ready) begin
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic push_exp(input bit zero_key);
        exp_t e;
        for (int i = 0; i <= 10; i++) begin
            e.idx = 4'(i);
            if (zero_key) begin
                e.key     = (i == 1) ? zero_rk1 : 128'd0;
                e.chk_key = (i <= 1);
            end else begin
                e.key     = a1_keys[i];
                e.chk_key = 1'b1;
            end
            sb_q.push_back(e);
        end
    endtask

    // Called at posedge+1; leaves the bench at posedge+1 of the done cycle (or after reset)
    task automatic do_stream(input bit zero_key, input int stall_at, input int dup_at,
                             input int rst_at, input int exp_lat);
        int cyc;
        int stall_cnt;
        bit dup_done;
        bit rst_pend;
        cyc = 0;
        stall_cnt = 0;
        dup_done = 1'b0;
        rst_pend = 1'b0;
        push_exp(zero_key);
        key_in   = zero_key ? 128'd0 : a1_keys[0];
        start    = 1'b1;
        rk_ready = 1'b1;
        while (1) begin
            @(posedge clk);
            cyc++;
            #1;
            start = 1'b0;
            if (cyc == 1) begin
                check_val("done_clear", {127'd0, done}, 128'd0);
`ifdef KEY_EXP_STORE_EN
                check_val("store_valid_clear", {127'd0, store_valid}, 128'd0);
`endif
            end
            if (rst_pend) begin
                rst = 1'b0;
                check_val("rst_busy", {127'd0, busy}, 128'd0);
                check_val("rst_valid", {127'd0, rk_valid}, 128'd0);
                check_val("rst_rk", rk, 128'd0);
                check_val("rst_idx", {124'd0, rk_idx}, 128'd0);
                check_val("rst_done", {127'd0, done}, 128'd0);
                sb_q.delete();
                return;
            end
            if (done) begin
                check_val("done_latency", cyc, exp_lat);
                check_val("busy_at_done", {127'd0, busy}, 128'd0);
                check_val("sb_drained", sb_q.size(), 128'd0);
                return;
            end
            if (cyc > 100) begin
                check_val("timeout_done", {127'd0, done}, 128'd1);
                sb_q.delete();
                return;
            end
            if (rk_valid && rk_idx == stall_at && stall_cnt < 3) begin
                rk_ready = 1'b0;
                stall_cnt++;
            end else begin
                rk_ready = 1'b1;
            end
            if (rk_valid && rk_idx == dup_at && !dup_done) begin
                start    = 1'b1;
                key_in   = 128'h00112233445566778899aabbccddeeff;
                dup_done = 1'b1;
            end
            if (rk_valid && rk_idx == rst_at) begin
                rst      = 1'b1;
                rst_pend = 1'b1;
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rk_ready = 1'b1;
        key_in   = 128'd0;
`ifdef KEY_EXP_STORE_EN
        rd_addr  = 4'd0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_busy", {127'd0, busy}, 128'd0);
        check_val("reset_valid", {127'd0, rk_valid}, 128'd0);
        check_val("reset_rk", rk, 128'd0);
        check_val("reset_idx", {124'd0, rk_idx}, 128'd0);
        check_val("reset_done", {127'd0, done}, 128'd0);
`ifdef KEY_EXP_STORE_EN
        check_val("reset_rd_data", rd_data, 128'd0);
        check_val("reset_store_valid", {127'd0, store_valid}, 128'd0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_stream(1'b0, -1, -1, -1, 12);
`ifdef KEY_EXP_STORE_EN
        check_val("store_valid_set", {127'd0, store_valid}, 128'd1);
        rd_addr = 4'd10;
        @(posedge clk);
        #1;
        check_val("rd_addr10", rd_data, a1_keys[10]);
        rd_addr = 4'd12;
        @(posedge clk);
        #1;
        check_val("rd_addr12", rd_data, 128'd0);
        rd_addr = 4'd3;
        @(posedge clk);
        #1;
        check_val("rd_addr3", rd_data, a1_keys[3]);
        check_val("store_valid_hold", {127'd0, store_valid}, 128'd1);
`endif
        // back-to-back: the next start lands in the done cycle of the previous run
        do_stream(1'b1, -1, -1, -1, 12);
        do_stream(1'b0, 4, -1, -1, 15);
        do_stream(1'b0, -1, 3, -1, 12);
        do_stream(1'b0, -1, -1, 6, 12);
        do_stream(1'b0, -1, -1, -1, 12);

        @(posedge clk);
        #1;
        check_val("idle_done_low", {127'd0, done}, 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_expansion.md
# key_expansion

AES-128 key expansion sequencer. It takes a 128-bit cipher key and produces round keys 0..10 one at a time over a valid/ready stream. It uses the team's `key_schedule` block to generate the g word (RotWord, SubWord and Rcon) of each round. It sits between key load and the round datapath, and optionally keeps all 11 round keys for reverse-order (decryption) readout.

## Interface

**Parameters**
- `NUM_ROUNDS`, default 10: number of expansion rounds. Only 10 (AES-128) is legal; elaboration fails on any other value.

**Ports** (name, direction, width, meaning)
- `clk` input 1: the single clock. All state changes on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: one-cycle request to expand `key_in`. Sampled only in IDLE.
- `key_in` input 128: cipher key. Word w0 = `[127:96]`, w3 = `[31:0]`.
- `busy` output 1: high from acceptance of `start` until the final handshake.
- `rk_valid` output 1: `rk` and `rk_idx` hold a valid round key.
- `rk_ready` input 1: the consumer accepts the key when `rk_valid & rk_ready` at a clock edge.
- `rk` output 128: current round key, same word order as `key_in`.
- `rk_idx` output 4: round index of `rk`, 0..10.
- `done` output 1: one-cycle pulse after round key 10 is accepted.
- `rd_addr` input 4: store read address. Present only with `KEY_EXP_STORE_EN`.
- `rd_data` output 128: stored round key. Present only with `KEY_EXP_STORE_EN`.
- `store_valid` output 1: store holds a complete key set. Present only with `KEY_EXP_STORE_EN`.

## Operation

**FSM states:** IDLE, EMIT.

**IDLE**
- `rk_valid = 0`, `busy = 0`.
- On `start`: latch `key_in` into the key register, set round counter to 0, go to EMIT.

**EMIT**
- `rk_valid = 1`, `rk` = key register, `rk_idx` = round counter.
- Handshake with `rk_idx < 10`:
  - key register ← next key;
  - round counter increments;
  - stay in EMIT.
- Handshake with `rk_idx == 10`: go to IDLE and pulse `done`.

**Next-key computation**
- g = `key_schedule` output with `key` = key register and `round_num` = `{8'd0, round counter + 1}`.
- n0 = w0 ^ g, n1 = w1 ^ n0, n2 = w2 ^ n1, n3 = w3 ^ n2. All are 32-bit XORs with no carries.
- The key register and round counter update on the same edge, so the round_num/key pair seen by `key_schedule` is always consistent.

**Boundary rules**
- `start` while busy: ignored. The sequence in flight is unaffected.
- `rk_valid` high with `rk_ready` low: `rk` and `rk_idx` stay stable, indefinitely if needed.
- The round counter never exceeds 10 and never wraps.
- `rst` and `start` in the same cycle: `rst` wins.
- `rst` mid-sequence: the block returns to IDLE at that edge and partial results are discarded.

## Timing

**Reset values**
- `busy` = 0, `rk_valid` = 0, `rk` = 0, `rk_idx` = 0, `done` = 0.
- With the store enabled: `rd_data` = 0, `store_valid` = 0.

**Latency and throughput**
- `start` sampled at edge N: `rk_valid` = 1 with `rk_idx` = 0 in cycle N+1.
- Throughput is one round key per cycle while `rk_ready` = 1.
- Minimum start-to-`done` time is 12 cycles: `done` is high in the cycle after the idx-10 handshake.

**Control outputs**
- `busy` falls in the same cycle that `done` pulses.
- A new `start` is accepted in the `done` cycle, because the FSM is already in IDLE.

## Configuration

**`KEY_EXP_STORE_EN` defined**
- An 11 × 128 register store is written at entry `rk_idx` on the first cycle each key becomes valid.
- `rd_data` = store[`rd_addr`] with one cycle of registered latency.
- `rd_addr` > 10 returns 0.
- `store_valid` rises with `done` and clears on `start` acceptance or `rst`.
- Store contents are not cleared by reset. Only `store_valid` is.

**`KEY_EXP_STORE_EN` undefined**
- The store and the `rd_addr`, `rd_data` and `store_valid` ports are absent.
- Streaming behaviour is identical in both builds.

## Test plan

- **FIPS-197 A.1 stream.** `start` with key 2b7e151628aed2a6abf7158809cf4f3c and `rk_ready` = 1 → `rk_idx` runs 0..10 on consecutive cycles. idx1 = a0fafe1788542cb123a339392a6c7605, idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6. `done` is high in cycle 12 after `start`.
- **All-zero key.** → idx1 = 62636363626363636263636362636363, with idx0 = 0.
- **Backpressure.** `rk_ready` = 0 for 3 cycles while idx 4 is valid → `rk` and idx stay stable, the sequence resumes, and all keys still match A.1.
- **`start` while busy.** Pulse `start` at idx 3 with a different `key_in` → ignored; the output sequence is unchanged.
- **Reset mid-sequence.** `rst` at idx 6 → all outputs are 0 after that edge. A new `start` restarts at idx 0 with correct keys.
- **Store readout (`KEY_EXP_STORE_EN`).** After `done` for the A.1 key:
  - `rd_addr` = 10 → `rd_data` = d014f9a8… the next cycle.
  - `rd_addr` = 12 → 0.
  - `store_valid` = 1 until the next `start`.
